// File: rtl/bitwise_oper_pipe.sv
// Registered bitwise operator (XOR/AND/OR/XNOR) with valid/ready flow control and an
// XOR-fold accumulate mode. Optional parity output enabled by BITWISE_OPER_PIPE_PARITY_EN.
module bitwise_oper_pipe #(
  parameter int WIDTH   = 4,
  parameter int ACC_LEN = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] co,
`ifdef BITWISE_OPER_PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_last
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] co_q, co_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] r;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    case (op)
      2'b00:   r = a ^ b;
      2'b01:   r = a & b;
      2'b10:   r = a | b;
      default: r = ~(a ^ b);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    co_d        = co_q;
    out_last_d  = out_last_q;
    // A consumed result drops valid unless a new one loads below.
    out_valid_d = out_valid_q && !out_ready;
    if (accept) begin
      if (state_q == IDLE) begin
        if (!acc_mode) begin
          co_d        = r;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          acc_d   = r;
          cnt_d   = CNT_W'(1);
          state_d = ACC;
        end
      end else if (cnt_q == CNT_W'(ACC_LEN - 1)) begin
        co_d        = acc_q ^ r;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = IDLE;
      end else begin
        acc_d = acc_q ^ r;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      co_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign co        = co_q;
  assign out_last  = out_last_q;

`ifdef BITWISE_OPER_PIPE_PARITY_EN
  logic parity_q;

  // co_d equals co_q when nothing loads, so parity tracks co under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^co_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_bitwise_oper_pipe.sv
// Bench for bitwise_oper_pipe: directed literal scenarios plus randomized traffic against a
// queue-based reference model, with one compare process checking outputs every cycle.
module tb_bitwise_oper_pipe;
  localparam int W = 4;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         acc_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] co;
  logic         out_last;
`ifdef BITWISE_OPER_PIPE_PARITY_EN
  logic         out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bitwise_oper_pipe #(.WIDTH(W), .ACC_LEN(L)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .co        (co),
`ifdef BITWISE_OPER_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of results awaiting consumption, list of beats in the open frame.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] frame[$];
  bit           in_frame = 0;
  logic [W-1:0] last_co = '0;
  bit           loaded = 0;

  function automatic logic [W-1:0] fop(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [1:0] o);
    case (o)
      2'd0:    return x ^ y;
      2'd1:    return x & y;
      2'd2:    return x | y;
      default: return ~(x ^ y);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        exp_q.delete();
        frame.delete();
        in_frame = 0;
        last_co  = '0;
        loaded   = 0;
      end else begin
        automatic bit           rdy = (exp_q.size() == 0) || out_ready;
        automatic logic [W-1:0] res;
        automatic logic [W-1:0] fold;
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && rdy) begin
          res = fop(a, b, op);
          if (!in_frame && !acc_mode) begin
            exp_q.push_back(res);
            last_co = res;
            loaded  = 1;
          end else begin
            in_frame = 1;
            frame.push_back(res);
            if (frame.size() == L) begin
              fold = '0;
              foreach (frame[i]) fold ^= frame[i];
              exp_q.push_back(fold);
              last_co  = fold;
              loaded   = 1;
              frame.delete();
              in_frame = 0;
            end
          end
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_co", 32'(co), 32'd0);
      end else begin
        check("m_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("m_co", 32'(co), 32'(last_co));
        check("m_last", 32'(out_last), 32'(loaded));
        check("m_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
`ifdef BITWISE_OPER_PIPE_PARITY_EN
        check("m_parity", 32'(out_parity), 32'(^last_co));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [1:0] oo, input bit m);
    in_valid = v;
    a        = aa;
    b        = bb;
    op       = oo;
    acc_mode = m;
  endtask

  task automatic expect_out(input string name, input bit v, input logic [W-1:0] c);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({name, "_co"}, 32'(co), 32'(c));
      check({name, "_last"}, 32'(out_last), 32'd1);
    end
  endtask

  initial begin
    step();
    step();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_co", 32'(co), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    rstn = 1'b1;
    step();
    check("post_reset_ready", 32'(in_ready), 32'd1);

    // Pass mode XOR, back-to-back.
    drive(1, 4'b1111, 4'b1001, 2'b00, 0); step(); expect_out("p1", 1, 4'b0110);
    check("p1_ready", 32'(in_ready), 32'd1);
    drive(1, 4'b0110, 4'b1001, 2'b00, 0); step(); expect_out("p2", 1, 4'b1111);
    drive(1, 4'b1000, 4'b1001, 2'b00, 0); step(); expect_out("p3", 1, 4'b0001);
    drive(0, 0, 0, 0, 0); step(); expect_out("p_drain", 0, 0);

    // Other operators.
    drive(1, 4'b1100, 4'b1010, 2'b01, 0); step(); expect_out("and", 1, 4'b1000);
    drive(1, 4'b1100, 4'b1010, 2'b10, 0); step(); expect_out("or", 1, 4'b1110);
    drive(1, 4'b1100, 4'b1010, 2'b11, 0); step(); expect_out("xnor", 1, 4'b1001);
    drive(0, 0, 0, 0, 0); step();

    // Backpressure, then consume and accept in the same cycle.
    drive(1, 4'b1111, 4'b1001, 2'b00, 0); step();
    drive(0, 0, 0, 0, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("bp_hold", 1, 4'b0110);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drive(1, 4'b0110, 4'b1001, 2'b00, 0); step(); expect_out("bp_swap", 1, 4'b1111);
    drive(0, 0, 0, 0, 0); step(); expect_out("bp_drain", 0, 0);
    check("bp_co_hold", 32'(co), 32'(4'b1111));

    // Accumulate frame of three beats.
    drive(1, 4'b1111, 4'b1001, 2'b00, 1); step(); expect_out("acc1", 0, 0);
    drive(1, 4'b0110, 4'b1001, 2'b00, 1); step(); expect_out("acc2", 0, 0);
    drive(1, 4'b1000, 4'b1001, 2'b00, 1); step(); expect_out("acc3", 1, 4'b1000);
    drive(0, 0, 0, 0, 0); step();

    // acc_mode dropped mid-frame is ignored.
    drive(1, 4'b1111, 4'b1001, 2'b00, 1); step(); expect_out("tog1", 0, 0);
    drive(1, 4'b0110, 4'b1001, 2'b00, 0); step(); expect_out("tog2", 0, 0);
    drive(1, 4'b1000, 4'b1001, 2'b00, 0); step(); expect_out("tog3", 1, 4'b1000);
    drive(0, 0, 0, 0, 0); step();

    // Reset in the middle of a frame.
    drive(1, 4'b1111, 4'b1001, 2'b00, 1); step();
    drive(1, 4'b0110, 4'b1001, 2'b00, 1); step();
    drive(0, 0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_co", 32'(co), 32'd0);
`ifdef BITWISE_OPER_PIPE_PARITY_EN
    check("mid_rst_parity", 32'(out_parity), 32'd0);
`endif
    step();
    rstn = 1'b1;
    drive(1, 4'b1111, 4'b1001, 2'b00, 0); step(); expect_out("post_rst", 1, 4'b0110);
`ifdef BITWISE_OPER_PIPE_PARITY_EN
    check("post_rst_parity", 32'(out_parity), 32'd0);
`endif
    drive(1, 4'b1111, 4'b1001, 2'b00, 1); step();
    drive(1, 4'b0110, 4'b1001, 2'b00, 1); step(); expect_out("fresh2", 0, 0);
    drive(1, 4'b1000, 4'b1001, 2'b00, 1); step(); expect_out("fresh3", 1, 4'b1000);
    drive(0, 0, 0, 0, 0); step();

    // Randomized traffic, checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rstn = 1'b0;
        step();
        rstn = 1'b1;
      end
      drive(bit'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
            2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    out_ready = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
